alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu4.sv | 48 ++++
 rtl/alu_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU:
// opcodes, ALU select encodings and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [2:0] {
    SEL_ADD = 3'b000,
    SEL_SUB = 3'b001,
    SEL_NOT = 3'b010,
    SEL_AND = 3'b011,
    SEL_OR  = 3'b100,
    SEL_XOR = 3'b101,
    SEL_SLT = 3'b110,
    SEL_ZT  = 3'b111
  } sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU shared by single ops
// and the shift-add multiplier.
module alu4
  import alu_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  sel_e       sel_i,
  output logic [3:0] result_o,
  output logic       carry_o,
  output logic       overflow_o,
  output logic       zero_o
);

  logic [4:0] sum;
  logic [4:0] diff;

  // Subtract as a + ~b + 1; carry is the no-borrow flag.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;

  always_comb begin
    result_o   = 4'd0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    unique case (sel_i)
      SEL_ADD: begin
        result_o   = sum[3:0];
        carry_o    = sum[4];
        overflow_o = (a_i[3] == b_i[3]) && (sum[3] != a_i[3]);
      end
      SEL_SUB: begin
        result_o   = diff[3:0];
        carry_o    = diff[4];
        overflow_o = (a_i[3] != b_i[3]) && (diff[3] != a_i[3]);
      end
      SEL_NOT: result_o = ~a_i;
      SEL_AND: result_o = a_i & b_i;
      SEL_OR:  result_o = a_i | b_i;
      SEL_XOR: result_o = a_i ^ b_i;
      SEL_SLT: result_o = {3'b000, $signed(a_i) < $signed(b_i)};
      SEL_ZT:  result_o = {3'b000, a_i == 4'd0};
    endcase
  end

  assign zero_o = (result_o == 4'd0);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one command in flight, single ops in
// one cycle, 4x4 multiply by 4-step shift-add.
module alu_seq
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic       out_carry,
  output logic       out_overflow,
  output logic       out_zero,
  output logic       out_err
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [8:0]  acc_q, acc_d;
  logic [1:0]  step_q, step_d;
  logic        last_q, last_d;
  logic [7:0]  res_q, res_d;
  logic        cy_q, cy_d;
  logic        ov_q, ov_d;
  logic        zf_q, zf_d;
  logic        err_q, err_d;

  logic        in_mul;
  logic [3:0]  alu_a, alu_b, alu_r;
  sel_e        alu_sel;
  logic        alu_c, alu_v, alu_z;

  // The multiplier borrows the ALU adder for P_hi + a.
  assign in_mul  = (state_q == S_MUL);
  assign alu_a   = in_mul ? acc_q[7:4] : a_q;
  assign alu_b   = in_mul ? a_q : b_q;
  assign alu_sel = in_mul ? SEL_ADD : sel_e'(op_q[2:0]);

  alu4 u_alu (
    .a_i        (alu_a),
    .b_i        (alu_b),
    .sel_i      (alu_sel),
    .result_o   (alu_r),
    .carry_o    (alu_c),
    .overflow_o (alu_v),
    .zero_o     (alu_z)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    step_d  = step_q;
    last_d  = last_q;
    res_d   = res_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    zf_d    = zf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = {5'd0, in_b};
          step_d  = 2'd0;
          last_d  = 1'b0;
          state_d = (in_op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = op_q[3] ? 8'd0 : {4'd0, alu_r};
        cy_d    = op_q[3] ? 1'b0 : alu_c;
        ov_d    = op_q[3] ? 1'b0 : alu_v;
        zf_d    = op_q[3] ? 1'b0 : alu_z;
        err_d   = op_q[3];
        state_d = S_DONE;
      end
      S_MUL: begin
        if (last_q) begin
          res_d   = acc_q[7:0];
          cy_d    = 1'b0;
          ov_d    = 1'b0;
          zf_d    = (acc_q[7:0] == 8'd0);
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          acc_d  = acc_q[0] ? ({alu_c, alu_r, acc_q[3:0]} >> 1)
                            : ({1'b0, acc_q[7:0]} >> 1);
          step_d = step_q + 2'd1;
          last_d = (step_q == 2'd3);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      acc_q   <= 9'd0;
      step_q  <= 2'd0;
      last_q  <= 1'b0;
      res_q   <= 8'd0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      zf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      last_q  <= last_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
      zf_q    <= zf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign out_result   = res_q;
  assign out_carry    = cy_q;
  assign out_overflow = ov_q;
  assign out_zero     = zf_q;
  assign out_err      = err_q;

endmodule
